// File: rtl/pipe_regs.sv
// Y86-64 pipeline register bank (F, D, E, M, W) plus cycle/retired/bubble performance counters.
// Latency: one clk from upstream input to stage output; every output is a register.
// Backpressure: a stall holds a stage; a bubble loads a NOP; stall wins over bubble; reset wins over both.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   F_stall .. W_stall    - hazard controls, one per stage that supports them
//   f_*, d_*, e_*, m_*    - stage results feeding the next register (D, E, M, W)
//   F_*, D_*, E_*, M_*, W_* - registered stage contents
//   cnt_*                 - wrapping performance counters, CNT_W bits each
module pipe_regs #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             F_stall,
    input  logic             D_stall,
    input  logic             D_bubble,
    input  logic             E_bubble,
    input  logic             M_bubble,
    input  logic             W_stall,
    input  logic [63:0]      f_predPC,
    input  logic [1:0]       f_stat,
    input  logic [3:0]       f_icode,
    input  logic [3:0]       f_ifun,
    input  logic [3:0]       f_rA,
    input  logic [3:0]       f_rB,
    input  logic [63:0]      f_valC,
    input  logic [63:0]      f_valP,
    input  logic [1:0]       d_stat,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_ifun,
    input  logic [63:0]      d_valC,
    input  logic [63:0]      d_valA,
    input  logic [63:0]      d_valB,
    input  logic [3:0]       d_dstE,
    input  logic [3:0]       d_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [1:0]       e_stat,
    input  logic [3:0]       e_icode,
    input  logic             e_Cnd,
    input  logic [63:0]      e_valE,
    input  logic [63:0]      e_valA,
    input  logic [3:0]       e_dstE,
    input  logic [3:0]       e_dstM,
    input  logic [1:0]       m_stat,
    input  logic [3:0]       m_icode,
    input  logic [63:0]      m_valE,
    input  logic [63:0]      m_valM,
    input  logic [3:0]       m_dstE,
    input  logic [3:0]       m_dstM,
    output logic [63:0]      F_predPC,
    output logic [1:0]       D_stat,
    output logic [3:0]       D_icode,
    output logic [3:0]       D_ifun,
    output logic [3:0]       D_rA,
    output logic [3:0]       D_rB,
    output logic [63:0]      D_valC,
    output logic [63:0]      D_valP,
    output logic [1:0]       E_stat,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_ifun,
    output logic [63:0]      E_valC,
    output logic [63:0]      E_valA,
    output logic [63:0]      E_valB,
    output logic [3:0]       E_dstE,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB,
    output logic [1:0]       M_stat,
    output logic [3:0]       M_icode,
    output logic             M_Cnd,
    output logic [63:0]      M_valE,
    output logic [63:0]      M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM,
    output logic [1:0]       W_stat,
    output logic [3:0]       W_icode,
    output logic [63:0]      W_valE,
    output logic [63:0]      W_valM,
    output logic [3:0]       W_dstE,
    output logic [3:0]       W_dstM,
    output logic [CNT_W-1:0] cnt_cycles,
    output logic [CNT_W-1:0] cnt_retired,
    output logic [CNT_W-1:0] cnt_bubbles
);

    localparam logic [1:0] SAOK  = 2'd0;
    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode, ifun, rA, rB;
        logic [63:0] valC, valP;
    } d_reg_t;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode, ifun;
        logic [63:0] valC, valA, valB;
        logic [3:0]  dstE, dstM, srcA, srcB;
    } e_reg_t;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic        Cnd;
        logic [63:0] valE, valA;
        logic [3:0]  dstE, dstM;
    } m_reg_t;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE, valM;
        logic [3:0]  dstE, dstM;
    } w_reg_t;

    localparam d_reg_t D_BUBBLE = '{stat: SAOK, icode: INOP, ifun: 4'h0, rA: RNONE, rB: RNONE,
                                    valC: 64'd0, valP: 64'd0};
    localparam e_reg_t E_BUBBLE = '{stat: SAOK, icode: INOP, ifun: 4'h0, valC: 64'd0, valA: 64'd0,
                                    valB: 64'd0, dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};
    localparam m_reg_t M_BUBBLE = '{stat: SAOK, icode: INOP, Cnd: 1'b0, valE: 64'd0, valA: 64'd0,
                                    dstE: RNONE, dstM: RNONE};
    localparam w_reg_t W_BUBBLE = '{stat: SAOK, icode: INOP, valE: 64'd0, valM: 64'd0,
                                    dstE: RNONE, dstM: RNONE};

    logic [63:0] r_f_predpc;
    d_reg_t      r_d;
    e_reg_t      r_e;
    m_reg_t      r_m;
    w_reg_t      r_w;

    d_reg_t      w_d_in;
    e_reg_t      w_e_in;
    m_reg_t      w_m_in;
    w_reg_t      w_w_in;
    logic [1:0]  w_bub_cnt;
    logic        w_retire;

    assign w_d_in = '{stat: f_stat, icode: f_icode, ifun: f_ifun, rA: f_rA, rB: f_rB,
                      valC: f_valC, valP: f_valP};
    assign w_e_in = '{stat: d_stat, icode: d_icode, ifun: d_ifun, valC: d_valC, valA: d_valA,
                      valB: d_valB, dstE: d_dstE, dstM: d_dstM, srcA: d_srcA, srcB: d_srcB};
    assign w_m_in = '{stat: e_stat, icode: e_icode, Cnd: e_Cnd, valE: e_valE, valA: e_valA,
                      dstE: e_dstE, dstM: e_dstM};
    assign w_w_in = '{stat: m_stat, icode: m_icode, valE: m_valE, valM: m_valM,
                      dstE: m_dstE, dstM: m_dstM};

    // A D bubble overridden by D_stall inserts nothing, so it is not counted.
    assign w_bub_cnt = 2'(D_bubble & ~D_stall) + 2'(E_bubble) + 2'(M_bubble);
    // Retirement is judged on the W content leaving the stage at this edge.
    assign w_retire  = ~W_stall && (r_w.icode != INOP) && (r_w.stat == SAOK);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_f_predpc  <= RESET_PC;
            r_d         <= D_BUBBLE;
            r_e         <= E_BUBBLE;
            r_m         <= M_BUBBLE;
            r_w         <= W_BUBBLE;
            cnt_cycles  <= '0;
            cnt_retired <= '0;
            cnt_bubbles <= '0;
        end else begin
            if (!F_stall) r_f_predpc <= f_predPC;

            if (D_stall)       r_d <= r_d;
            else if (D_bubble) r_d <= D_BUBBLE;
            else               r_d <= w_d_in;

            r_e <= E_bubble ? E_BUBBLE : w_e_in;
            r_m <= M_bubble ? M_BUBBLE : w_m_in;
            if (!W_stall) r_w <= w_w_in;

            cnt_cycles  <= cnt_cycles + 1'b1;
            cnt_retired <= cnt_retired + CNT_W'(w_retire);
            cnt_bubbles <= cnt_bubbles + CNT_W'(w_bub_cnt);
        end
    end

    assign F_predPC = r_f_predpc;
    assign D_stat   = r_d.stat;
    assign D_icode  = r_d.icode;
    assign D_ifun   = r_d.ifun;
    assign D_rA     = r_d.rA;
    assign D_rB     = r_d.rB;
    assign D_valC   = r_d.valC;
    assign D_valP   = r_d.valP;
    assign E_stat   = r_e.stat;
    assign E_icode  = r_e.icode;
    assign E_ifun   = r_e.ifun;
    assign E_valC   = r_e.valC;
    assign E_valA   = r_e.valA;
    assign E_valB   = r_e.valB;
    assign E_dstE   = r_e.dstE;
    assign E_dstM   = r_e.dstM;
    assign E_srcA   = r_e.srcA;
    assign E_srcB   = r_e.srcB;
    assign M_stat   = r_m.stat;
    assign M_icode  = r_m.icode;
    assign M_Cnd    = r_m.Cnd;
    assign M_valE   = r_m.valE;
    assign M_valA   = r_m.valA;
    assign M_dstE   = r_m.dstE;
    assign M_dstM   = r_m.dstM;
    assign W_stat   = r_w.stat;
    assign W_icode  = r_w.icode;
    assign W_valE   = r_w.valE;
    assign W_valM   = r_w.valM;
    assign W_dstE   = r_w.dstE;
    assign W_dstM   = r_w.dstM;

endmodule

// File: tb/tb_pipe_regs.sv
module tb_pipe_regs;

    localparam logic [63:0] RPC = 64'h100;
    localparam int          CW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic [63:0] f_predPC, f_valC, f_valP, d_valC, d_valA, d_valB, e_valE, e_valA, m_valE, m_valM;
    logic [1:0]  f_stat, d_stat, e_stat, m_stat;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
    logic [3:0]  e_icode, e_dstE, e_dstM, m_icode, m_dstE, m_dstM;
    logic        e_Cnd;

    logic [63:0] F_predPC, D_valC, D_valP, E_valC, E_valA, E_valB, M_valE, M_valA, W_valE, W_valM;
    logic [1:0]  D_stat, E_stat, M_stat, W_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [3:0]  M_icode, M_dstE, M_dstM, W_icode, W_dstE, W_dstM;
    logic        M_Cnd;
    logic [CW-1:0] cnt_cycles, cnt_retired, cnt_bubbles;

    pipe_regs #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .f_predPC(f_predPC), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
        .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
        .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd), .e_valE(e_valE),
        .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
        .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
        .m_dstE(m_dstE), .m_dstM(m_dstM),
        .F_predPC(F_predPC),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM),
        .cnt_cycles(cnt_cycles), .cnt_retired(cnt_retired), .cnt_bubbles(cnt_bubbles)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every stage must hold the bubble, F_predPC the reset PC, counters zero.
    task automatic chk_reset_state(input string tag);
        chk({tag, " F_predPC"}, F_predPC, RPC);
        chk({tag, " D_stat"}, D_stat, 0);   chk({tag, " D_icode"}, D_icode, 1);
        chk({tag, " D_ifun"}, D_ifun, 0);   chk({tag, " D_rA"}, D_rA, 4'hF);
        chk({tag, " D_rB"}, D_rB, 4'hF);    chk({tag, " D_valC"}, D_valC, 0);
        chk({tag, " D_valP"}, D_valP, 0);
        chk({tag, " E_stat"}, E_stat, 0);   chk({tag, " E_icode"}, E_icode, 1);
        chk({tag, " E_ifun"}, E_ifun, 0);   chk({tag, " E_valC"}, E_valC, 0);
        chk({tag, " E_valA"}, E_valA, 0);   chk({tag, " E_valB"}, E_valB, 0);
        chk({tag, " E_dstE"}, E_dstE, 4'hF); chk({tag, " E_dstM"}, E_dstM, 4'hF);
        chk({tag, " E_srcA"}, E_srcA, 4'hF); chk({tag, " E_srcB"}, E_srcB, 4'hF);
        chk({tag, " M_stat"}, M_stat, 0);   chk({tag, " M_icode"}, M_icode, 1);
        chk({tag, " M_Cnd"}, M_Cnd, 0);     chk({tag, " M_valE"}, M_valE, 0);
        chk({tag, " M_valA"}, M_valA, 0);   chk({tag, " M_dstE"}, M_dstE, 4'hF);
        chk({tag, " M_dstM"}, M_dstM, 4'hF);
        chk({tag, " W_stat"}, W_stat, 0);   chk({tag, " W_icode"}, W_icode, 1);
        chk({tag, " W_valE"}, W_valE, 0);   chk({tag, " W_valM"}, W_valM, 0);
        chk({tag, " W_dstE"}, W_dstE, 4'hF); chk({tag, " W_dstM"}, W_dstM, 4'hF);
        chk({tag, " cnt_cycles"}, cnt_cycles, 0);
        chk({tag, " cnt_retired"}, cnt_retired, 0);
        chk({tag, " cnt_bubbles"}, cnt_bubbles, 0);
    endtask

    typedef struct {
        logic        fs, ds, db, eb, mb, ws;
        logic [63:0] pc;
        logic [3:0]  fi;
        logic [63:0] fc;
        logic [3:0]  di, ei, mi;
        logic [1:0]  ms;
        logic [63:0] x_pc;
        logic [3:0]  x_d;
        logic [63:0] x_c;
        logic [3:0]  x_e, x_edm, x_m, x_w;
        logic [1:0]  x_ws;
        logic [3:0]  x_cyc, x_ret, x_bub;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // fs ds db eb mb ws | pc fi fc | di ei mi ms | x_pc x_d x_c x_e x_edm x_m x_w x_ws cyc ret bub
        vecs[0]  = '{0,0,0,0,0,0, 64'h108,3,64'h10,  6,2,5,0, 64'h108,3,64'h10,  6,4'h3,2,5,0,  1, 0,0};
        vecs[1]  = '{0,0,0,0,0,0, 64'h110,4,64'h20,  3,6,2,0, 64'h110,4,64'h20,  3,4'h3,6,2,0,  2, 1,0};
        vecs[2]  = '{1,1,0,1,0,0, 64'h118,7,64'h30,  4,3,6,0, 64'h110,4,64'h20,  1,4'hF,3,6,0,  3, 2,1};
        vecs[3]  = '{0,0,1,1,0,0, 64'h120,2,64'h40,  7,4,3,0, 64'h120,1,64'h0,   1,4'hF,4,3,0,  4, 3,3};
        vecs[4]  = '{0,0,0,0,0,0, 64'h128,5,64'h50,  2,5,4,0, 64'h128,5,64'h50,  2,4'h3,5,4,0,  5, 4,3};
        vecs[5]  = '{0,1,1,0,0,0, 64'h130,6,64'h60,  3,2,5,0, 64'h130,5,64'h50,  3,4'h3,2,5,0,  6, 5,3};
        vecs[6]  = '{0,0,0,0,1,0, 64'h138,3,64'h70,  6,3,2,0, 64'h138,3,64'h70,  6,4'h3,1,2,0,  7, 6,4};
        vecs[7]  = '{0,0,0,0,0,0, 64'h140,2,64'h80,  4,5,6,0, 64'h140,2,64'h80,  4,4'h3,5,6,0,  8, 7,4};
        vecs[8]  = '{0,0,0,0,0,1, 64'h148,4,64'h90,  7,2,3,0, 64'h148,4,64'h90,  7,4'h3,2,6,0,  9, 7,4};
        vecs[9]  = '{0,0,0,0,0,1, 64'h150,5,64'hA0,  3,4,2,0, 64'h150,5,64'hA0,  3,4'h3,4,6,0, 10, 7,4};
        vecs[10] = '{0,0,0,0,0,1, 64'h158,6,64'hB0,  2,6,4,0, 64'h158,6,64'hB0,  2,4'h3,6,6,0, 11, 7,4};
        vecs[11] = '{0,0,0,0,0,0, 64'h160,7,64'hC0,  5,2,1,0, 64'h160,7,64'hC0,  5,4'h3,2,1,0, 12, 8,4};
        vecs[12] = '{0,0,0,0,0,0, 64'h168,2,64'hD0,  4,3,3,0, 64'h168,2,64'hD0,  4,4'h3,3,3,0, 13, 8,4};
        vecs[13] = '{0,0,0,0,0,0, 64'h170,3,64'hE0,  2,5,0,1, 64'h170,3,64'hE0,  2,4'h3,5,0,1, 14, 9,4};
        vecs[14] = '{0,0,0,0,0,0, 64'h178,4,64'hF0,  6,2,4,0, 64'h178,4,64'hF0,  6,4'h3,2,4,0, 15, 9,4};
        vecs[15] = '{0,0,0,0,0,0, 64'h180,5,64'h100, 3,6,2,0, 64'h180,5,64'h100, 3,4'h3,6,2,0,  0,10,4};

        // Non-table fields carry non-bubble values so reset/bubble loads are observable.
        reset = 1'b1;
        {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} = '0;
        f_predPC = 64'h777; f_stat = 2'd0; f_icode = 4'h3; f_ifun = 4'h2; f_rA = 4'h1; f_rB = 4'h2;
        f_valC = 64'h55; f_valP = 64'h1234;
        d_stat = 2'd0; d_icode = 4'h6; d_ifun = 4'h1; d_valC = 64'h11; d_valA = 64'h22;
        d_valB = 64'h33; d_dstE = 4'h2; d_dstM = 4'h3; d_srcA = 4'h4; d_srcB = 4'h5;
        e_stat = 2'd0; e_icode = 4'h2; e_Cnd = 1'b1; e_valE = 64'h44; e_valA = 64'h66;
        e_dstE = 4'h6; e_dstM = 4'h7;
        m_stat = 2'd0; m_icode = 4'h5; m_valE = 64'h88; m_valM = 64'h99; m_dstE = 4'h8; m_dstM = 4'h9;

        @(posedge clk); #1;
        chk_reset_state("reset");
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} =
                {vecs[i].fs, vecs[i].ds, vecs[i].db, vecs[i].eb, vecs[i].mb, vecs[i].ws};
            f_predPC = vecs[i].pc; f_icode = vecs[i].fi; f_valC = vecs[i].fc;
            d_icode  = vecs[i].di; e_icode = vecs[i].ei; m_icode = vecs[i].mi; m_stat = vecs[i].ms;
            @(posedge clk); #1;
            chk($sformatf("v%0d F_predPC", i), F_predPC, vecs[i].x_pc);
            chk($sformatf("v%0d D_icode", i), D_icode, vecs[i].x_d);
            chk($sformatf("v%0d D_valC", i), D_valC, vecs[i].x_c);
            chk($sformatf("v%0d E_icode", i), E_icode, vecs[i].x_e);
            chk($sformatf("v%0d E_dstM", i), E_dstM, vecs[i].x_edm);
            chk($sformatf("v%0d M_icode", i), M_icode, vecs[i].x_m);
            chk($sformatf("v%0d W_icode", i), W_icode, vecs[i].x_w);
            chk($sformatf("v%0d W_stat", i), W_stat, vecs[i].x_ws);
            chk($sformatf("v%0d cnt_cycles", i), cnt_cycles, vecs[i].x_cyc);
            chk($sformatf("v%0d cnt_retired", i), cnt_retired, vecs[i].x_ret);
            chk($sformatf("v%0d cnt_bubbles", i), cnt_bubbles, vecs[i].x_bub);
        end

        // Full-field pass-through on a normal edge.
        {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} = '0;
        m_stat = 2'd0; d_icode = 4'h6; e_icode = 4'h2; m_icode = 4'h5;
        @(posedge clk); #1;
        chk("pass D_rA", D_rA, 4'h1);      chk("pass D_valP", D_valP, 64'h1234);
        chk("pass E_valB", E_valB, 64'h33); chk("pass E_srcB", E_srcB, 4'h5);
        chk("pass M_Cnd", M_Cnd, 1'b1);     chk("pass M_dstM", M_dstM, 4'h7);
        chk("pass W_valM", W_valM, 64'h99); chk("pass W_dstE", W_dstE, 4'h8);

        // Mid-run reset with valid instructions in flight and stalls asserted: reset wins.
        reset = 1'b1;
        {F_stall, D_stall, W_stall} = 3'b111;
        @(posedge clk); #1;
        chk_reset_state("midreset");

        // First edge after reset loads normally.
        reset = 1'b0;
        {F_stall, D_stall, W_stall} = 3'b000;
        f_predPC = 64'h200; f_icode = 4'h3; f_valC = 64'h10;
        @(posedge clk); #1;
        chk("post F_predPC", F_predPC, 64'h200);
        chk("post D_icode", D_icode, 4'h3);
        chk("post D_valC", D_valC, 64'h10);
        chk("post cnt_cycles", cnt_cycles, 1);
        chk("post cnt_retired", cnt_retired, 0);
        chk("post cnt_bubbles", cnt_bubbles, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
